// File: rtl/ept_xlate.sv
// ept_xlate: VMID-tagged, fully-associative guest->host page translation cache with a single-outstanding walker miss path.
// Hit latency 1 cycle, miss = walk round trip + 1; one request in flight, response held until resp_ready_i, req_ready_o only when idle.
module ept_xlate #(
   parameter int VMID_W      = 8,
   parameter int PA_W        = 64,
   parameter int PAGE_SHIFT  = 12,
   parameter int TLB_ENTRIES = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic [VMID_W-1:0]          req_vmid_i,
   input  logic [PA_W-1:0]            req_gpa_i,
   input  logic [1:0]                 req_acc_i,
   output logic                       resp_valid_o,
   input  logic                       resp_ready_i,
   output logic [PA_W-1:0]            resp_hpa_o,
   output logic                       resp_fault_o,
   output logic                       walk_req_valid_o,
   input  logic                       walk_req_ready_i,
   output logic [VMID_W-1:0]          walk_req_vmid_o,
   output logic [PA_W-PAGE_SHIFT-1:0] walk_req_gpn_o,
   input  logic                       walk_resp_valid_i,
   input  logic [PA_W-PAGE_SHIFT-1:0] walk_resp_hpn_i,
   input  logic [2:0]                 walk_resp_perm_i,
   input  logic                       walk_resp_fault_i,
   input  logic                       inv_valid_i,
   input  logic                       inv_all_i,
   input  logic [VMID_W-1:0]          inv_vmid_i,
   output logic [31:0]                hit_cnt_o,
   output logic [31:0]                miss_cnt_o
);

   localparam int GPN_W = PA_W - PAGE_SHIFT;
   localparam int IDX_W = $clog2(TLB_ENTRIES);

   typedef struct packed {
      logic              vld;
      logic [VMID_W-1:0] vmid;
      logic [GPN_W-1:0]  gpn;
      logic [GPN_W-1:0]  hpn;
      logic [2:0]        perm;
   } tlb_entry_t;

   typedef enum logic [1:0] {IDLE, WALK_REQ, WALK_WAIT, RESP} state_t;

   state_t                state_q, state_d;
   tlb_entry_t            tlb_q [TLB_ENTRIES];
   logic [VMID_W-1:0]     cur_vmid_q;
   logic [GPN_W-1:0]      cur_gpn_q;
   logic [PAGE_SHIFT-1:0] cur_off_q;
   logic [1:0]            cur_acc_q;
   logic [PA_W-1:0]       resp_hpa_q;
   logic                  resp_fault_q;
   logic                  fill_kill_q;
   logic [IDX_W-1:0]      rr_ptr_q;
   logic [31:0]           hit_cnt_q, miss_cnt_q;

   logic [GPN_W-1:0]      req_gpn;
   logic [PAGE_SHIFT-1:0] req_off;
   logic                  hit_any, lookup_hit, accept;
   logic [GPN_W-1:0]      hit_hpn;
   logic [2:0]            hit_perm;
   logic                  free_found;
   logic [IDX_W-1:0]      free_idx, fill_idx;
   logic                  inv_req_match, inv_cur_match;
   logic                  hit_fault, walk_fault, walk_done, fill_en;
   logic [PA_W-1:0]       hit_hpa, walk_hpa;

   function automatic logic perm_ok(input logic [2:0] perm, input logic [1:0] acc);
      case (acc)
         2'd0:    return perm[0];
         2'd1:    return perm[1];
         2'd2:    return perm[2];
         default: return 1'b0;
      endcase
   endfunction

   assign req_gpn = req_gpa_i[PA_W-1:PAGE_SHIFT];
   assign req_off = req_gpa_i[PAGE_SHIFT-1:0];

   // Fills only happen after a miss on the same tag, so at most one entry can match.
   always_comb begin
      hit_any    = 1'b0;
      hit_hpn    = '0;
      hit_perm   = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
         if (tlb_q[i].vld && tlb_q[i].vmid == req_vmid_i && tlb_q[i].gpn == req_gpn) begin
            hit_any  = 1'b1;
            hit_hpn  = tlb_q[i].hpn;
            hit_perm = tlb_q[i].perm;
         end
      end
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if (!tlb_q[i].vld) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   assign inv_req_match = inv_valid_i & (inv_all_i | (inv_vmid_i == req_vmid_i));
   assign inv_cur_match = inv_valid_i & (inv_all_i | (inv_vmid_i == cur_vmid_q));
   assign lookup_hit    = hit_any & ~inv_req_match;
   assign accept        = req_valid_i & req_ready_o;

   assign hit_fault  = ~perm_ok(hit_perm, req_acc_i);
   assign hit_hpa    = hit_fault ? '0 : {hit_hpn, req_off};
   assign walk_fault = walk_resp_fault_i | ~perm_ok(walk_resp_perm_i, cur_acc_q);
   assign walk_hpa   = walk_fault ? '0 : {walk_resp_hpn_i, cur_off_q};

   // Walker faults are never cached; permission faults on a good walk still are.
   assign walk_done = (state_q == WALK_WAIT) & walk_resp_valid_i;
   assign fill_en   = walk_done & ~walk_resp_fault_i & ~fill_kill_q & ~inv_cur_match;
   assign fill_idx  = free_found ? free_idx : rr_ptr_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d          = state_q;
      req_ready_o      = 1'b0;
      resp_valid_o     = 1'b0;
      walk_req_valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_o = ~rst;
            if (req_valid_i && !rst) state_d = lookup_hit ? RESP : WALK_REQ;
         end
         WALK_REQ: begin
            walk_req_valid_o = ~rst;
            if (walk_req_ready_i) state_d = WALK_WAIT;
         end
         WALK_WAIT: begin
            if (walk_resp_valid_i) state_d = RESP;
         end
         RESP: begin
            resp_valid_o = ~rst;
            if (resp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign resp_hpa_o      = rst ? '0 : resp_hpa_q;
   assign resp_fault_o    = rst ? 1'b0 : resp_fault_q;
   assign walk_req_vmid_o = rst ? '0 : cur_vmid_q;
   assign walk_req_gpn_o  = rst ? '0 : cur_gpn_q;
   assign hit_cnt_o       = hit_cnt_q;
   assign miss_cnt_o      = miss_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_vmid_q   <= '0;
         cur_gpn_q    <= '0;
         cur_off_q    <= '0;
         cur_acc_q    <= '0;
         resp_hpa_q   <= '0;
         resp_fault_q <= 1'b0;
         fill_kill_q  <= 1'b0;
         rr_ptr_q     <= '0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         if (accept) begin
            cur_vmid_q  <= req_vmid_i;
            cur_gpn_q   <= req_gpn;
            cur_off_q   <= req_off;
            cur_acc_q   <= req_acc_i;
            fill_kill_q <= 1'b0;
            if (lookup_hit) begin
               resp_hpa_q   <= hit_hpa;
               resp_fault_q <= hit_fault;
               if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
               if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
         end else if ((state_q == WALK_REQ || state_q == WALK_WAIT) && inv_cur_match) begin
            fill_kill_q <= 1'b1;
         end
         if (walk_done) begin
            resp_hpa_q   <= walk_hpa;
            resp_fault_q <= walk_fault;
         end
         if (fill_en && !free_found) rr_ptr_q <= rr_ptr_q + IDX_W'(1);
      end
   end

   // Victim selection sees pre-invalidate valid bits; the invalidate lands in the same edge.
   always_ff @(posedge clk) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
         if (rst) begin
            tlb_q[i].vld <= 1'b0;
         end else if (fill_en && fill_idx == IDX_W'(i)) begin
            tlb_q[i] <= '{vld: 1'b1, vmid: cur_vmid_q, gpn: cur_gpn_q,
                          hpn: walk_resp_hpn_i, perm: walk_resp_perm_i};
         end else if (inv_valid_i && (inv_all_i || tlb_q[i].vmid == inv_vmid_i)) begin
            tlb_q[i].vld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ept_xlate.sv
// Directed plus randomized bench for ept_xlate against an array-based translation cache model.
module tb_ept_xlate;
   localparam int VMID_W = 8;
   localparam int PA_W   = 64;
   localparam int PS     = 12;
   localparam int N      = 8;
   localparam int GPN_W  = PA_W - PS;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0, req_ready;
   logic [VMID_W-1:0] req_vmid = '0;
   logic [PA_W-1:0]   req_gpa = '0;
   logic [1:0]        req_acc = '0;
   logic              resp_valid, resp_ready = 1'b0, resp_fault;
   logic [PA_W-1:0]   resp_hpa;
   logic              walk_req_valid, walk_req_ready = 1'b0;
   logic [VMID_W-1:0] walk_req_vmid;
   logic [GPN_W-1:0]  walk_req_gpn;
   logic              walk_resp_valid = 1'b0, walk_resp_fault = 1'b0;
   logic [GPN_W-1:0]  walk_resp_hpn = '0;
   logic [2:0]        walk_resp_perm = '0;
   logic              inv_valid = 1'b0, inv_all = 1'b0;
   logic [VMID_W-1:0] inv_vmid = '0;
   logic [31:0]       hit_cnt, miss_cnt;

   ept_xlate #(.VMID_W(VMID_W), .PA_W(PA_W), .PAGE_SHIFT(PS), .TLB_ENTRIES(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_vmid_i(req_vmid),
      .req_gpa_i(req_gpa), .req_acc_i(req_acc),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_hpa_o(resp_hpa),
      .resp_fault_o(resp_fault),
      .walk_req_valid_o(walk_req_valid), .walk_req_ready_i(walk_req_ready),
      .walk_req_vmid_o(walk_req_vmid), .walk_req_gpn_o(walk_req_gpn),
      .walk_resp_valid_i(walk_resp_valid), .walk_resp_hpn_i(walk_resp_hpn),
      .walk_resp_perm_i(walk_resp_perm), .walk_resp_fault_i(walk_resp_fault),
      .inv_valid_i(inv_valid), .inv_all_i(inv_all), .inv_vmid_i(inv_vmid),
      .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference cache: plain arrays, fill into lowest free slot else round-robin victim.
   bit                m_vld  [N];
   logic [VMID_W-1:0] m_vmid [N];
   logic [GPN_W-1:0]  m_gpn  [N];
   logic [GPN_W-1:0]  m_hpn  [N];
   logic [2:0]        m_perm [N];
   int                m_rr = 0;
   int                m_hits = 0;
   int                m_misses = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
      m_rr = 0; m_hits = 0; m_misses = 0;
   endtask

   function automatic int model_lookup(input logic [VMID_W-1:0] vmid, input logic [GPN_W-1:0] gpn);
      for (int i = 0; i < N; i++)
         if (m_vld[i] && m_vmid[i] == vmid && m_gpn[i] == gpn) return i;
      return -1;
   endfunction

   task automatic model_inv(input bit all, input logic [VMID_W-1:0] vmid);
      for (int i = 0; i < N; i++)
         if (all || m_vmid[i] == vmid) m_vld[i] = 1'b0;
   endtask

   task automatic model_fill(input logic [VMID_W-1:0] vmid, input logic [GPN_W-1:0] gpn,
                             input logic [GPN_W-1:0] hpn, input logic [2:0] perm);
      int v;
      v = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_vld[i]) v = i;
      if (v < 0) begin
         v = m_rr;
         m_rr = (m_rr + 1) % N;
      end
      m_vld[v] = 1'b1; m_vmid[v] = vmid; m_gpn[v] = gpn; m_hpn[v] = hpn; m_perm[v] = perm;
   endtask

   function automatic bit perm_allows(input logic [2:0] perm, input logic [1:0] acc);
      case (acc)
         2'd0:    return perm[0];
         2'd1:    return perm[1];
         2'd2:    return perm[2];
         default: return 1'b0;
      endcase
   endfunction

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
      chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("rst_resp_hpa", resp_hpa, 64'd0);
      chk("rst_resp_fault", {63'd0, resp_fault}, 64'd0);
      chk("rst_walk_valid", {63'd0, walk_req_valid}, 64'd0);
      chk("rst_walk_vmid", {56'd0, walk_req_vmid}, 64'd0);
      chk("rst_walk_gpn", {12'd0, walk_req_gpn}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      model_reset();
      chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
      chk("post_rst_hits", {32'd0, hit_cnt}, 64'd0);
      chk("post_rst_misses", {32'd0, miss_cnt}, 64'd0);
   endtask

   task automatic do_inv(input bit all, input logic [VMID_W-1:0] vmid);
      inv_valid = 1'b1; inv_all = all; inv_vmid = vmid;
      @(negedge clk);
      inv_valid = 1'b0; inv_all = 1'b0;
      model_inv(all, vmid);
   endtask

   // inv_mode: 0 none, 1 with acceptance, 2 while waiting on walker, 3 with walker response.
   task automatic xlate(input logic [VMID_W-1:0] vmid, input logic [PA_W-1:0] gpa, input logic [1:0] acc,
                        input logic [GPN_W-1:0] whpn, input logic [2:0] wperm, input bit wfault,
                        input int inv_mode, input bit iall, input logic [VMID_W-1:0] ivmid,
                        input int wreq_stall, input int wwait, input int rstall,
                        output logic [PA_W-1:0] o_hpa, output logic o_fault, output logic o_walked);
      logic [GPN_W-1:0] gpn;
      logic [PS-1:0]    off;
      logic [PA_W-1:0]  ehpa;
      bit               efault, hit, imatch, fill_ok;
      int               idx;
      gpn = gpa[PA_W-1:PS];
      off = gpa[PS-1:0];
      imatch = iall || (ivmid == vmid);
      idx = model_lookup(vmid, gpn);
      hit = (idx >= 0) && !(inv_mode == 1 && imatch);
      efault = 1'b0; ehpa = '0;
      if (hit) begin
         efault = (acc == 2'd3) || !perm_allows(m_perm[idx], acc);
         ehpa = efault ? 64'd0 : {m_hpn[idx], off};
      end
      req_valid = 1'b1; req_vmid = vmid; req_gpa = gpa; req_acc = acc;
      if (inv_mode == 1) begin inv_valid = 1'b1; inv_all = iall; inv_vmid = ivmid; end
      chk("accept_ready", {63'd0, req_ready}, 64'd1);
      @(negedge clk);
      req_valid = 1'b0; inv_valid = 1'b0; inv_all = 1'b0;
      if (inv_mode == 1) model_inv(iall, ivmid);
      if (hit) m_hits++; else m_misses++;
      o_walked = walk_req_valid;
      chk("walk_req_on_miss", {63'd0, walk_req_valid}, {63'd0, !hit});
      chk("resp_lat1_on_hit", {63'd0, resp_valid}, {63'd0, hit});
      if (!hit) begin
         for (int k = 0; k <= wreq_stall; k++) begin
            chk("walk_req_held", {63'd0, walk_req_valid}, 64'd1);
            chk("walk_req_vmid", {56'd0, walk_req_vmid}, {56'd0, vmid});
            chk("walk_req_gpn", {12'd0, walk_req_gpn}, {12'd0, gpn});
            if (k == wreq_stall) walk_req_ready = 1'b1;
            @(negedge clk);
         end
         walk_req_ready = 1'b0;
         chk("walk_req_drop", {63'd0, walk_req_valid}, 64'd0);
         for (int k = 0; k < wwait; k++) begin
            chk("wait_no_resp", {63'd0, resp_valid}, 64'd0);
            @(negedge clk);
         end
         fill_ok = !wfault;
         if (inv_mode == 2) begin
            do_inv(iall, ivmid);
            if (imatch) fill_ok = 1'b0;
         end
         walk_resp_valid = 1'b1; walk_resp_hpn = whpn; walk_resp_perm = wperm; walk_resp_fault = wfault;
         if (inv_mode == 3) begin inv_valid = 1'b1; inv_all = iall; inv_vmid = ivmid; end
         @(negedge clk);
         walk_resp_valid = 1'b0; inv_valid = 1'b0; inv_all = 1'b0;
         if (inv_mode == 3 && imatch) fill_ok = 1'b0;
         if (fill_ok) model_fill(vmid, gpn, whpn, wperm);
         if (inv_mode == 3) model_inv(iall, ivmid);
         efault = wfault || (acc == 2'd3) || !perm_allows(wperm, acc);
         ehpa = efault ? 64'd0 : {whpn, off};
      end
      o_hpa = resp_hpa; o_fault = resp_fault;
      for (int k = 0; k <= rstall; k++) begin
         chk("resp_valid_held", {63'd0, resp_valid}, 64'd1);
         chk("resp_hpa", resp_hpa, ehpa);
         chk("resp_fault", {63'd0, resp_fault}, {63'd0, efault});
         chk("busy_not_ready", {63'd0, req_ready}, 64'd0);
         if (k == rstall) resp_ready = 1'b1;
         @(negedge clk);
      end
      resp_ready = 1'b0;
      chk("resp_drop", {63'd0, resp_valid}, 64'd0);
      chk("idle_ready", {63'd0, req_ready}, 64'd1);
      chk("hit_cnt", {32'd0, hit_cnt}, 64'(m_hits));
      chk("miss_cnt", {32'd0, miss_cnt}, 64'(m_misses));
   endtask

   initial begin
      logic [PA_W-1:0] hpa;
      logic            flt, walked;
      logic [GPN_W-1:0] rh;

      reset_dut();

      // miss then hit
      xlate(8'd3, 64'h1234_5678, 2'd0, 52'hABCDE, 3'b001, 1'b0, 0, 1'b0, 8'd0, 1, 2, 0, hpa, flt, walked);
      chk("miss_hpa_const", hpa, 64'hABCD_E678);
      chk("miss_fault_const", {63'd0, flt}, 64'd0);
      chk("miss_walked", {63'd0, walked}, 64'd1);
      xlate(8'd3, 64'h1234_5678, 2'd0, 52'h0, 3'b000, 1'b0, 0, 1'b0, 8'd0, 0, 0, 0, hpa, flt, walked);
      chk("hit_hpa_const", hpa, 64'hABCD_E678);
      chk("hit_no_walk", {63'd0, walked}, 64'd0);
      chk("hit_cnt_const", {32'd0, hit_cnt}, 64'd1);
      chk("miss_cnt_const", {32'd0, miss_cnt}, 64'd1);

      // permission fault on a cached read-only page
      xlate(8'd3, 64'h1234_5ABC, 2'd1, 52'h0, 3'b000, 1'b0, 0, 1'b0, 8'd0, 0, 0, 0, hpa, flt, walked);
      chk("perm_fault", {63'd0, flt}, 64'd1);
      chk("perm_fault_hpa", hpa, 64'd0);
      chk("perm_no_walk", {63'd0, walked}, 64'd0);

      // invalidate coinciding with acceptance forces a miss
      xlate(8'd3, 64'h1234_5678, 2'd0, 52'h11111, 3'b111, 1'b0, 1, 1'b0, 8'd3, 0, 0, 0, hpa, flt, walked);
      chk("inv_accept_walked", {63'd0, walked}, 64'd1);

      // walker fault is not cached
      xlate(8'd4, 64'h0000_7000, 2'd0, 52'h22222, 3'b111, 1'b1, 0, 1'b0, 8'd0, 0, 1, 0, hpa, flt, walked);
      chk("walk_fault", {63'd0, flt}, 64'd1);
      chk("walk_fault_hpa", hpa, 64'd0);
      xlate(8'd4, 64'h0000_7000, 2'd0, 52'h22222, 3'b111, 1'b0, 0, 1'b0, 8'd0, 0, 0, 0, hpa, flt, walked);
      chk("walk_fault_rewalk", {63'd0, walked}, 64'd1);

      // per-VMID invalidate
      xlate(8'd2, 64'h0002_0010, 2'd0, 52'h30000, 3'b011, 1'b0, 0, 1'b0, 8'd0, 0, 0, 0, hpa, flt, walked);
      xlate(8'd5, 64'h0005_0020, 2'd2, 52'h50000, 3'b100, 1'b0, 0, 1'b0, 8'd0, 0, 0, 0, hpa, flt, walked);
      do_inv(1'b0, 8'd2);
      xlate(8'd2, 64'h0002_0010, 2'd0, 52'h30001, 3'b011, 1'b0, 0, 1'b0, 8'd0, 0, 0, 0, hpa, flt, walked);
      chk("inv_vmid2_miss", {63'd0, walked}, 64'd1);
      xlate(8'd5, 64'h0005_0020, 2'd2, 52'h0, 3'b000, 1'b0, 0, 1'b0, 8'd0, 0, 0, 0, hpa, flt, walked);
      chk("inv_vmid5_hit", {63'd0, walked}, 64'd0);
      chk("inv_vmid5_hpa", hpa, 64'h5000_0020);
      xlate(8'd5, 64'h0005_9000, 2'd0, 52'h59000, 3'b001, 1'b0, 2, 1'b0, 8'd5, 0, 1, 0, hpa, flt, walked);
      chk("inv_walk_delivered", hpa, 64'h5900_0000);
      xlate(8'd5, 64'h0005_9000, 2'd0, 52'h59000, 3'b001, 1'b0, 3, 1'b0, 8'd5, 0, 0, 0, hpa, flt, walked);
      chk("inv_walk_not_filled", {63'd0, walked}, 64'd1);

      // response backpressure
      xlate(8'd2, 64'h0002_0010, 2'd1, 52'h0, 3'b000, 1'b0, 0, 1'b0, 8'd0, 0, 0, 5, hpa, flt, walked);

      // reset while waiting on the walker, late walker response ignored
      req_valid = 1'b1; req_vmid = 8'd7; req_gpa = 64'h0007_7000; req_acc = 2'd0;
      @(negedge clk);
      req_valid = 1'b0; walk_req_ready = 1'b1;
      @(negedge clk);
      walk_req_ready = 1'b0;
      reset_dut();
      walk_resp_valid = 1'b1; walk_resp_hpn = 52'h77777; walk_resp_perm = 3'b111; walk_resp_fault = 1'b0;
      @(negedge clk);
      walk_resp_valid = 1'b0;
      chk("late_walk_no_resp", {63'd0, resp_valid}, 64'd0);
      chk("late_walk_ready", {63'd0, req_ready}, 64'd1);
      xlate(8'd7, 64'h0007_7000, 2'd0, 52'h77778, 3'b111, 1'b0, 0, 1'b0, 8'd0, 0, 0, 0, hpa, flt, walked);
      chk("late_walk_not_cached", {63'd0, walked}, 64'd1);

      // eviction: ninth distinct page replaces entry 0
      reset_dut();
      for (int i = 0; i <= N; i++)
         xlate(8'd1, 64'(64'h100 + i) << PS, 2'd0, 52'(52'h8000 + i), 3'b001, 1'b0, 0, 1'b0, 8'd0,
               0, 0, 0, hpa, flt, walked);
      xlate(8'd1, 64'h100 << PS, 2'd0, 52'h9000, 3'b001, 1'b0, 0, 1'b0, 8'd0, 0, 0, 0, hpa, flt, walked);
      chk("evict_first_miss", {63'd0, walked}, 64'd1);
      xlate(8'd1, 64'h100 << PS, 2'd0, 52'h0, 3'b000, 1'b0, 0, 1'b0, 8'd0, 0, 0, 0, hpa, flt, walked);
      chk("evict_second_hit", {63'd0, walked}, 64'd0);
      xlate(8'd1, 64'h102 << PS, 2'd0, 52'h0, 3'b000, 1'b0, 0, 1'b0, 8'd0, 0, 0, 0, hpa, flt, walked);
      chk("evict_survivor_hit", {63'd0, walked}, 64'd0);

      // randomized traffic over a small tag space so hits, evictions and invalidates mix
      for (int t = 0; t < 120; t++) begin
         int sel, im;
         sel = $urandom_range(0, 9);
         im = (sel < 3) ? sel + 1 : 0;
         rh = 52'({$urandom(), $urandom()});
         if ($urandom_range(0, 9) == 0) do_inv($urandom_range(0, 3) == 0, 8'($urandom_range(0, 3)));
         xlate(8'($urandom_range(0, 3)), {52'($urandom_range(0, 11)), 12'($urandom())},
               2'($urandom_range(0, 3)), rh, 3'($urandom()), $urandom_range(0, 7) == 0,
               im, $urandom_range(0, 3) == 0, 8'($urandom_range(0, 3)),
               $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), hpa, flt, walked);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ept_xlate.md
EPT_XLATE -- requirements
Module: ept_xlate

Interface
REQ-001 Parameter VMID_W, 8, VM identifier width.
REQ-002 Parameter PA_W, 64, guest/host physical address width.
REQ-003 Parameter PAGE_SHIFT, 12, page offset bits; page number = PA_W-PAGE_SHIFT bits.
REQ-004 Parameter TLB_ENTRIES, 8, fully-associative entries, power of two >= 2.
REQ-005 Ports: clk in 1 clock; rst in 1 synchronous active-high reset, sampled on rising clk.
REQ-006 req_valid_i in 1, req_ready_o out 1, req_vmid_i in VMID_W, req_gpa_i in PA_W, req_acc_i in 2 (0 read, 1 write, 2 exec, 3 reserved).
REQ-007 resp_valid_o out 1, resp_ready_i in 1, resp_hpa_o out PA_W, resp_fault_o out 1.
REQ-008 walk_req_valid_o out 1, walk_req_ready_i in 1, walk_req_vmid_o out VMID_W, walk_req_gpn_o out PA_W-PAGE_SHIFT.
REQ-009 walk_resp_valid_i in 1, walk_resp_hpn_i in PA_W-PAGE_SHIFT, walk_resp_perm_i in 3 ({x,w,r}), walk_resp_fault_i in 1.
REQ-010 inv_valid_i in 1, inv_all_i in 1, inv_vmid_i in VMID_W: TLB invalidate command.
REQ-011 hit_cnt_o out 32, miss_cnt_o out 32: saturating statistics.

Function
REQ-012 FSM states IDLE, WALK_REQ, WALK_WAIT, RESP; one translation outstanding.
REQ-013 req_ready_o = 1 only in IDLE; handshake when req_valid_i & req_ready_o.
REQ-014 Hit: valid entry with matching vmid and gpn; response registered, resp_valid_o high the cycle after acceptance (latency 1); FSM -> RESP.
REQ-015 Hit output: resp_hpa_o = {entry hpn, gpa[PAGE_SHIFT-1:0]}; resp_fault_o = 1 if perm bit for req_acc_i is 0 or req_acc_i = 3, then resp_hpa_o = 0.
REQ-016 Miss: FSM -> WALK_REQ; walk_req_valid_o high with vmid/gpn held stable until walk_req_ready_i; then -> WALK_WAIT.
REQ-017 WALK_WAIT: on walk_resp_valid_i, response formed as REQ-015 using walker hpn/perm; walk_resp_fault_i forces resp_fault_o = 1, resp_hpa_o = 0; -> RESP.
REQ-018 Fill: non-faulting walk result written to TLB in same cycle as walk_resp_valid_i; faulting results never cached; permission faults on a valid walk still cache the entry.
REQ-019 Replacement: first invalid entry (lowest index); if none, round-robin pointer victim, pointer increments mod TLB_ENTRIES per victim fill.
REQ-020 RESP: resp_* held stable until resp_ready_i; on resp_valid_o & resp_ready_i -> IDLE, next request accepted no earlier than following cycle.
REQ-021 Invalidate: inv_valid_i & inv_all_i clears all entries; inv_valid_i & ~inv_all_i clears entries with vmid = inv_vmid_i; effective from next cycle, accepted in any state.
REQ-022 Invalidate same cycle as request acceptance with matching vmid (or all): lookup treated as miss.
REQ-023 Matching invalidate while in WALK_REQ/WALK_WAIT (including cycle of walk_resp_valid_i): fill suppressed, response still delivered.
REQ-024 hit_cnt_o increments per accepted hit, miss_cnt_o per accepted miss; both stick at 32'hFFFF_FFFF.
REQ-025 walk_resp_valid_i outside WALK_WAIT ignored.

Reset
REQ-026 rst: FSM -> IDLE, all TLB valid bits 0, round-robin pointer 0, counters 0.
REQ-027 During rst: req_ready_o 0, resp_valid_o 0, resp_hpa_o 0, resp_fault_o 0, walk_req_valid_o 0, walk_req_vmid_o 0, walk_req_gpn_o 0; req_ready_o = 1 first cycle after rst deasserts.
REQ-028 rst mid-walk abandons translation; later walk_resp_valid_i ignored per REQ-025.

Verification
REQ-029 Miss then hit: vmid 3, gpa 0x1234_5678, read; walker returns hpn 0xABCDE, perm 3'b001 -> resp_hpa 0xABCDE678, fault 0; repeat -> resp 1 cycle after accept, no walk_req, hit_cnt 1, miss_cnt 1.
REQ-030 Permission fault: cached entry perm 3'b001, write access -> resp_fault 1, resp_hpa 0, no walk issued.
REQ-031 Walker fault: walk_resp_fault_i 1 -> resp_fault 1; same gpa again -> new walk_req (not cached).
REQ-032 Eviction: TLB_ENTRIES+1 distinct gpns for vmid 1 -> ninth fill replaces entry 0; first gpn re-request misses, second hits.
REQ-033 Invalidate: entries for vmid 2 and 5; inv vmid 2 -> vmid 2 misses, vmid 5 hits; inv during WALK_WAIT for vmid 5 -> response delivered, next same request misses.
REQ-034 Backpressure/reset: resp_ready_i low 5 cycles -> outputs stable, req_ready_o 0; rst in WALK_WAIT -> IDLE, counters 0, late walk_resp ignored.
